// File: rtl/pipe_sequencer.sv
// Pipeline sequencing controller: freeze, branch flush, load-use stall and Halt drain.
// Optional stall/flush performance counters are built when PIPE_PERF_EN is defined.
module pipe_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       id_opcode,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_mem_read,
    input  logic [3:0]       ex_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [3:0]  OP_HALT = 4'b1111;
    localparam int unsigned DW      = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } state_e;

    state_e        state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;

    logic freeze;
    logic lu;
    logic halt_op;

    assign freeze  = mem_req & ~mem_ready;
    assign lu      = ex_mem_read & ((id_rs1_used & (id_rs1 == ex_rd)) |
                                    (id_rs2_used & (id_rs2 == ex_rd)));
    assign halt_op = (id_opcode == OP_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Next state and Mealy enables; reset forces the safe NOP-loading values.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        halted      = 1'b0;

        if (!rst_n) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (freeze) begin
                        // everything holds; a taken branch waits in EX
                    end else if (ex_branch_taken) begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        idex_write  = 1'b1;
                        exmem_write = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (lu) begin
                        idex_write  = 1'b1;
                        exmem_write = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (halt_op) begin
                        idex_write  = 1'b1;
                        exmem_write = 1'b1;
                        state_d     = ST_DRAIN;
                        drain_d     = '0;
                    end else begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        idex_write  = 1'b1;
                        exmem_write = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    idex_bubble = 1'b1;
                    idex_write  = ~freeze;
                    exmem_write = ~freeze;
                    if (!freeze) begin
                        drain_d = drain_q + DW'(1);
                        if (drain_d == DW'(DRAIN_CYCLES)) begin
                            state_d = ST_HALTED;
                        end
                    end
                end
                ST_HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    state_d = ST_RUN;
                    drain_d = '0;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    logic             stall_ev;
    logic             flush_ev;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    assign stall_ev = (state_q == ST_RUN) & (freeze | (~ex_branch_taken & lu));
    assign flush_ev = (state_q == ST_RUN) & ~freeze & ex_branch_taken;

    // Saturating event counters, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_ev && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (flush_ev && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
